// File: rtl/arm_pkg.sv
// Shared definitions for the 5-stage ARM core: widths, ALU command
// encodings and the control bundle carried from ID to EXE.
package arm_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int CMD_W      = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } id_exe_ctrl_t;

  // A non-valid ID slot must not leak any side-effecting control bit.
  function automatic id_exe_ctrl_t gate_ctrl(input id_exe_ctrl_t c, input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/pipe_reg_fcl.sv
// Generic pipeline register: async active-low reset, flush-to-zero
// (highest priority), freeze-hold, otherwise load.
module pipe_reg_fcl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         freeze,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = '0;
    end else if (!freeze) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: holds decoded operands and control for the
// EXE stage, with hazard freeze, branch flush and a valid bit.
module id_exe_stage_reg #(
  parameter int DATA_W     = arm_pkg::DATA_W,
  parameter int REG_ADDR_W = arm_pkg::REG_ADDR_W,
  parameter int CMD_W      = arm_pkg::CMD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_val_rn,
  input  logic [DATA_W-1:0]     id_val_rm,
  input  logic [11:0]           id_shift_operand,
  input  logic                  id_imm,
  input  logic [23:0]           id_signed_imm_24,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [CMD_W-1:0]      id_exe_cmd,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic                  id_wb_en,
  input  logic                  id_b,
  input  logic                  id_s,
  input  logic                  id_status_c,
  output logic                  exe_valid,
  output logic [DATA_W-1:0]     exe_pc,
  output logic [DATA_W-1:0]     exe_val_rn,
  output logic [DATA_W-1:0]     exe_val_rm,
  output logic [11:0]           exe_shift_operand,
  output logic                  exe_imm,
  output logic [23:0]           exe_signed_imm_24,
  output logic [REG_ADDR_W-1:0] exe_dest,
  output logic [REG_ADDR_W-1:0] exe_src1,
  output logic [REG_ADDR_W-1:0] exe_src2,
  output logic [CMD_W-1:0]      exe_exe_cmd,
  output logic                  exe_mem_r_en,
  output logic                  exe_mem_w_en,
  output logic                  exe_wb_en,
  output logic                  exe_b,
  output logic                  exe_s,
  output logic                  exe_status_c,
  output logic                  exe_ldr_or_str
);

  import arm_pkg::id_exe_ctrl_t;
  import arm_pkg::gate_ctrl;

  localparam int DATA_VEC_W = 3 * DATA_W + 12 + 1 + 24 + 3 * REG_ADDR_W + CMD_W + 1;
  localparam int CTRL_VEC_W = $bits(id_exe_ctrl_t) + 2;

  logic [DATA_VEC_W-1:0] data_vec_in;
  logic [DATA_VEC_W-1:0] data_vec_out;
  logic [CTRL_VEC_W-1:0] ctrl_vec_in;
  logic [CTRL_VEC_W-1:0] ctrl_vec_out;

  id_exe_ctrl_t ctrl_raw;
  id_exe_ctrl_t ctrl_gated;
  id_exe_ctrl_t ctrl_out;
  logic         ldr_or_str_in;

  assign data_vec_in = {id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm,
                        id_signed_imm_24, id_dest, id_src1, id_src2, id_exe_cmd,
                        id_status_c};

  always_comb begin
    ctrl_raw          = '0;
    ctrl_raw.wb_en    = id_wb_en;
    ctrl_raw.mem_r_en = id_mem_r_en;
    ctrl_raw.mem_w_en = id_mem_w_en;
    ctrl_raw.b        = id_b;
    ctrl_raw.s        = id_s;
  end

  // Memory-access select is derived from the already-gated bits so the
  // registered copy can never disagree with exe_mem_r_en/exe_mem_w_en.
  assign ctrl_gated    = gate_ctrl(ctrl_raw, id_valid);
  assign ldr_or_str_in = ctrl_gated.mem_r_en | ctrl_gated.mem_w_en;
  assign ctrl_vec_in   = {id_valid, ldr_or_str_in, ctrl_gated};

  pipe_reg_fcl #(.W(DATA_VEC_W)) u_data_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .freeze (freeze),
    .d_i    (data_vec_in),
    .q_o    (data_vec_out)
  );

  pipe_reg_fcl #(.W(CTRL_VEC_W)) u_ctrl_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .freeze (freeze),
    .d_i    (ctrl_vec_in),
    .q_o    (ctrl_vec_out)
  );

  assign {exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_imm,
          exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_exe_cmd,
          exe_status_c} = data_vec_out;

  assign {exe_valid, exe_ldr_or_str, ctrl_out} = ctrl_vec_out;

  assign exe_wb_en    = ctrl_out.wb_en;
  assign exe_mem_r_en = ctrl_out.mem_r_en;
  assign exe_mem_w_en = ctrl_out.mem_w_en;
  assign exe_b        = ctrl_out.b;
  assign exe_s        = ctrl_out.s;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: directed scenarios plus randomized traffic,
// scored against a cycle-level model of the stage register's rules.
module tb_id_exe_stage_reg;
  import arm_pkg::*;

  localparam int OW = 157;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [11:0] id_shift_operand;
  logic        id_imm;
  logic [23:0] id_signed_imm_24;
  logic [3:0]  id_dest, id_src1, id_src2, id_exe_cmd;
  logic        id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s, id_status_c;

  logic        exe_valid;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic [11:0] exe_shift_operand;
  logic        exe_imm;
  logic [23:0] exe_signed_imm_24;
  logic [3:0]  exe_dest, exe_src1, exe_src2, exe_exe_cmd;
  logic        exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_status_c;
  logic        exe_ldr_or_str;

  int n_checks;
  int n_errors;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] cur_exp;

  id_exe_stage_reg dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .freeze            (freeze),
    .flush             (flush),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_val_rn         (id_val_rn),
    .id_val_rm         (id_val_rm),
    .id_shift_operand  (id_shift_operand),
    .id_imm            (id_imm),
    .id_signed_imm_24  (id_signed_imm_24),
    .id_dest           (id_dest),
    .id_src1           (id_src1),
    .id_src2           (id_src2),
    .id_exe_cmd        (id_exe_cmd),
    .id_mem_r_en       (id_mem_r_en),
    .id_mem_w_en       (id_mem_w_en),
    .id_wb_en          (id_wb_en),
    .id_b              (id_b),
    .id_s              (id_s),
    .id_status_c       (id_status_c),
    .exe_valid         (exe_valid),
    .exe_pc            (exe_pc),
    .exe_val_rn        (exe_val_rn),
    .exe_val_rm        (exe_val_rm),
    .exe_shift_operand (exe_shift_operand),
    .exe_imm           (exe_imm),
    .exe_signed_imm_24 (exe_signed_imm_24),
    .exe_dest          (exe_dest),
    .exe_src1          (exe_src1),
    .exe_src2          (exe_src2),
    .exe_exe_cmd       (exe_exe_cmd),
    .exe_mem_r_en      (exe_mem_r_en),
    .exe_mem_w_en      (exe_mem_w_en),
    .exe_wb_en         (exe_wb_en),
    .exe_b             (exe_b),
    .exe_s             (exe_s),
    .exe_status_c      (exe_status_c),
    .exe_ldr_or_str    (exe_ldr_or_str)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] observed();
    return {exe_valid, exe_ldr_or_str, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s,
            exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_imm, exe_signed_imm_24,
            exe_dest, exe_src1, exe_src2, exe_exe_cmd, exe_status_c};
  endfunction

  // What a load of the present ID inputs should produce.
  function automatic logic [OW-1:0] loaded_view();
    logic v;
    v = id_valid;
    return {v, v & (id_mem_r_en | id_mem_w_en), v & id_wb_en, v & id_mem_r_en,
            v & id_mem_w_en, v & id_b, v & id_s,
            id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm, id_signed_imm_24,
            id_dest, id_src1, id_src2, id_exe_cmd, id_status_c};
  endfunction

  function automatic logic [OW-1:0] model_next(input logic [OW-1:0] prev);
    if (flush) return '0;
    if (freeze) return prev;
    return loaded_view();
  endfunction

  // driver tasks
  task automatic drive_idle();
    freeze = 0; flush = 0; id_valid = 0;
    id_pc = '0; id_val_rn = '0; id_val_rm = '0; id_shift_operand = '0; id_imm = 0;
    id_signed_imm_24 = '0; id_dest = '0; id_src1 = '0; id_src2 = '0; id_exe_cmd = '0;
    id_mem_r_en = 0; id_mem_w_en = 0; id_wb_en = 0; id_b = 0; id_s = 0; id_status_c = 0;
  endtask

  task automatic drive_random_id();
    id_valid         = 1'($urandom_range(0, 3) != 0);
    id_pc            = $urandom;
    id_val_rn        = $urandom;
    id_val_rm        = $urandom;
    id_shift_operand = 12'($urandom);
    id_imm           = 1'($urandom);
    id_signed_imm_24 = 24'($urandom);
    id_dest          = 4'($urandom);
    id_src1          = 4'($urandom);
    id_src2          = 4'($urandom);
    id_exe_cmd       = 4'($urandom_range(0, 9));
    id_mem_r_en      = 1'($urandom);
    id_mem_w_en      = 1'($urandom);
    id_wb_en         = 1'($urandom);
    id_b             = 1'($urandom);
    id_s             = 1'($urandom);
    id_status_c      = 1'($urandom);
  endtask

  // One clock edge, scored against the model.
  task automatic step(input string tag);
    logic [OW-1:0] e;
    exp_q.push_back(model_next(cur_exp));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, observed(), e);
    cur_exp = e;
  endtask

  task automatic async_reset_pulse(input string tag);
    #3;
    rst_n = 0;
    #1;
    check_eq(tag, observed(), '0);
    #2;
    rst_n = 1;
    cur_exp = '0;
  endtask

  initial begin
    logic [OW-1:0] held;
    n_checks = 0;
    n_errors = 0;
    cur_exp  = '0;
    rst_n    = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", observed(), '0);
    #5;
    rst_n = 1;

    // Reset acts without a clock edge
    drive_random_id();
    id_valid = 1; id_wb_en = 1; id_pc = 32'hDEAD_BEEF; id_dest = 4'hF;
    step("load_before_reset");
    async_reset_pulse("async_reset");

    // Normal load
    drive_idle();
    id_valid = 1; id_pc = 32'h0000_0010; id_val_rm = 32'hF000_000F;
    id_shift_operand = 12'h0E3; id_mem_r_en = 1; id_dest = 4'd4;
    step("normal_load");
    check_eq("load_ldr_or_str", OW'(exe_ldr_or_str), OW'(1));
    check_eq("load_valid", OW'(exe_valid), OW'(1));
    check_eq("load_pc", OW'(exe_pc), OW'(32'h0000_0010));
    check_eq("load_rm", OW'(exe_val_rm), OW'(32'hF000_000F));

    // Freeze three edges while ID changes, then release
    held = cur_exp;
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      drive_random_id();
      step("freeze_hold");
      check_eq("freeze_unchanged", observed(), held);
    end
    freeze = 0;
    drive_random_id();
    id_valid = 1; id_val_rn = 32'h1234_5678;
    step("freeze_release");
    check_eq("release_rn", OW'(exe_val_rn), OW'(32'h1234_5678));

    // Flush a valid ADD with writeback
    drive_idle();
    id_valid = 1; id_exe_cmd = CMD_ADD; id_wb_en = 1; id_dest = 4'd7; id_src1 = 4'd2;
    step("load_add");
    check_eq("add_wb", OW'(exe_wb_en), OW'(1));
    flush = 1;
    step("flush_bubble");
    check_eq("flush_valid", OW'(exe_valid), OW'(0));
    check_eq("flush_dest", OW'(exe_dest), OW'(0));
    check_eq("flush_cmd", OW'(exe_exe_cmd), OW'(0));
    drive_random_id();
    step("flush_back_to_back");

    // Flush wins over freeze
    drive_idle();
    id_valid = 1; id_wb_en = 1; id_pc = 32'h40;
    step("load_pre_ff");
    flush = 1; freeze = 1;
    step("flush_and_freeze");
    check_eq("ff_wb_en", OW'(exe_wb_en), OW'(0));
    flush = 0;
    step("held_bubble");

    // Invalid ID with stray control bits
    drive_idle();
    id_valid = 0; id_mem_w_en = 1; id_wb_en = 1; id_b = 1; id_s = 1; id_pc = 32'h88;
    step("invalid_id");
    check_eq("inv_mem_w", OW'(exe_mem_w_en), OW'(0));
    check_eq("inv_ldr_or_str", OW'(exe_ldr_or_str), OW'(0));
    check_eq("inv_pc_passes", OW'(exe_pc), OW'(32'h88));

    // Reset in the middle of a stall
    drive_random_id();
    id_valid = 1; id_mem_r_en = 1;
    step("load_pre_stall");
    freeze = 1;
    step("stall");
    async_reset_pulse("reset_mid_stall");
    step("stall_after_reset");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive_random_id();
      flush  = 1'($urandom_range(0, 7) == 0);
      freeze = 1'($urandom_range(0, 3) == 0);
      step("random");
      if ($urandom_range(0, 49) == 0) async_reset_pulse("random_reset");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the Decode (ID) stage and the Execute (EXE) stage of the 5-stage ARM core.
- Captures decoded control and operands each cycle and presents them, registered, to the EXE stage: Val2 generation, ALU and branch adder.
- Supports hazard freeze (hold), branch flush (bubble insertion) and a valid bit.
- Derives the memory-access select that the Val2 generation logic needs.

Parameters:
- DATA_W, 32, width of PC and register operands
- REG_ADDR_W, 4, register-file address width
- CMD_W, 4, ALU execute-command width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  hazard stall: hold current contents
- flush  in  1  branch taken in EXE: load a bubble
- id_valid  in  1  ID stage holds a real instruction
- id_pc  in  DATA_W  PC+4 of the ID instruction
- id_val_rn  in  DATA_W  Rn read value
- id_val_rm  in  DATA_W  Rm read value
- id_shift_operand  in  12  instruction bits [11:0]
- id_imm  in  1  I bit
- id_signed_imm_24  in  24  branch offset field
- id_dest  in  REG_ADDR_W  destination register
- id_src1, id_src2  in  REG_ADDR_W  source register numbers (for forwarding)
- id_exe_cmd  in  CMD_W  ALU command
- id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s  in  1 each  control bits
- id_status_c  in  1  carry flag sampled in ID
- exe_* outputs  out  same widths  registered copies of every id_* input above
- exe_valid  out  1  EXE holds a real instruction
- exe_ldr_or_str  out  1  exe_mem_r_en | exe_mem_w_en, registered

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0. This includes exe_valid, all control bits and exe_exe_cmd (NOP encoding 4'b0000). Reset mid-stall or mid-flush discards everything.
- Priority at each rising edge: flush > freeze > load.
- flush=1 (regardless of freeze) loads a bubble:
  - exe_valid, wb_en, mem_r_en, mem_w_en, b, s and exe_ldr_or_str are cleared to 0.
  - Data fields (pc, values, shift_operand, dest, src1, src2, cmd) are cleared to 0, so no stale src matches reach forwarding.
- freeze=1, flush=0: all registers hold their previous value. A held bubble stays a bubble.
- Otherwise, load:
  - All exe_* fields take the id_* values.
  - Control bits (wb_en, mem_r_en, mem_w_en, b, s) are gated: each is id_x & id_valid.
  - exe_valid takes id_valid.
- exe_ldr_or_str is computed from the gated id_mem_r_en/id_mem_w_en at load. It is registered, never combinational from the outputs.
- Latency: exactly 1 cycle from ID input to EXE output. No combinational path from any input to any output.
- Boundaries:
  - Back-to-back flush: repeated bubbles.
  - Freeze lasting N cycles: contents unchanged for N edges; the first edge after release loads the current ID inputs.
  - Flush and freeze in the same cycle: bubble.
  - id_valid=0 with stray control bits set: no side effects propagate.

Decomposition:
- Shared package `arm_pkg`:
  - DATA_W, REG_ADDR_W, CMD_W
  - exe_cmd encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, NOP=0)
  - packed struct `id_exe_ctrl_t` {wb_en, mem_r_en, mem_w_en, b, s}
- One sub-module: `pipe_reg_fcl`, a generic width-parameterized register with async active-low reset, flush-to-zero and freeze-hold. Instantiated once for data fields and once for control fields, with valid gating applied before the control instance.

Test Plan:
- Reset: drive all id_* nonzero, pulse rst_n low between edges -> all exe_* read 0 immediately, without waiting for a clock edge.
- Normal load: id_valid=1, id_pc=0x0000_0010, id_val_rm=0xF000_000F, id_shift_operand=0x0E3, id_mem_r_en=1, id_dest=4 -> next edge: exe_* equal the inputs, exe_ldr_or_str=1, exe_valid=1.
- Freeze: after the load above, freeze=1 for 3 cycles while the id_* inputs change -> exe_* unchanged for 3 edges; on the 4th edge (freeze=0) the new values appear.
- Flush: exe holds a valid ADD with wb_en=1; flush=1 -> next edge: exe_valid=0, exe_wb_en=0, exe_ldr_or_str=0, exe_dest=0, exe_exe_cmd=0.
- Flush+freeze together, with id_valid=1 and id_wb_en=1 -> bubble loaded, not held contents.
- Invalid ID: id_valid=0, id_mem_w_en=1, id_wb_en=1 -> exe_mem_w_en=0, exe_wb_en=0, exe_ldr_or_str=0, exe_valid=0.
